// File: rtl/rf_pkg.sv
// ============================================================================
// Module      : rf_pkg
// Description : Shared FunSel encodings, context-engine state type and the
//               register next-value helper for param_register_file.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_pkg;

    // FunSel write operations
    localparam logic [2:0] RF_DEC   = 3'b000;
    localparam logic [2:0] RF_INC   = 3'b001;
    localparam logic [2:0] RF_LOAD  = 3'b010;
    localparam logic [2:0] RF_CLR   = 3'b011;
    localparam logic [2:0] RF_LOZ   = 3'b100;
    localparam logic [2:0] RF_LOW   = 3'b101;
    localparam logic [2:0] RF_HIGH  = 3'b110;
    localparam logic [2:0] RF_SEXT  = 3'b111;

    // Widest register the helper can compute; cells cast in and out of it
    localparam int RF_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAVE    = 2'd1,
        RESTORE = 2'd2
    } rf_state_t;

    // Next register value for a FunSel op on a w-bit register.
    // Operands are zero-extended to RF_MAX_W; the result is masked to w bits.
    function automatic logic [RF_MAX_W-1:0] rf_next(
        input logic [RF_MAX_W-1:0] q,
        input logic [RF_MAX_W-1:0] d,
        input logic [2:0]          fs,
        input int unsigned         w
    );
        logic [RF_MAX_W-1:0] full_m;
        logic [RF_MAX_W-1:0] lo_m;
        logic [RF_MAX_W-1:0] msb_m;
        logic [RF_MAX_W-1:0] r;
        int unsigned         h;
        h      = w / 2;
        full_m = (w >= RF_MAX_W) ? '1 : ((RF_MAX_W'(1) << w) - RF_MAX_W'(1));
        lo_m   = (RF_MAX_W'(1) << h) - RF_MAX_W'(1);
        msb_m  = lo_m & ~(lo_m >> 1);
        case (fs)
            RF_DEC:  r = q - RF_MAX_W'(1);
            RF_INC:  r = q + RF_MAX_W'(1);
            RF_LOAD: r = d;
            RF_CLR:  r = '0;
            RF_LOZ:  r = d & lo_m;
            RF_LOW:  r = (q & ~lo_m) | (d & lo_m);
            RF_HIGH: r = (q & lo_m) | ((d & lo_m) << h);
            default: r = (d & lo_m) | ((|(d & msb_m)) ? (full_m & ~lo_m) : '0);
        endcase
        return r & full_m;
    endfunction

endpackage

`default_nettype wire

// File: rtl/param_register_file_if.sv
// ============================================================================
// Module      : param_register_file_if
// Description : Bus bundle between the ALU system and the register file:
//               write data/op/selects, read selects, context requests and
//               the read/status outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface param_register_file_if #(
    parameter int WIDTH   = 16,
    parameter int NUM_GP  = 4,
    parameter int NUM_SCR = 4
);
    localparam int SEL_W = $clog2(NUM_GP + NUM_SCR);

    logic [WIDTH-1:0]   wdata;
    logic [2:0]         fun_sel;
    logic [NUM_GP-1:0]  reg_sel;
    logic [NUM_SCR-1:0] scr_sel;
    logic [SEL_W-1:0]   out_a_sel;
    logic [SEL_W-1:0]   out_b_sel;
    logic               save_req;
    logic               restore_req;
    logic [WIDTH-1:0]   out_a;
    logic [WIDTH-1:0]   out_b;
    logic               busy;
    logic               done;

    modport master (
        output wdata, fun_sel, reg_sel, scr_sel, out_a_sel, out_b_sel,
               save_req, restore_req,
        input  out_a, out_b, busy, done
    );

    modport slave (
        input  wdata, fun_sel, reg_sel, scr_sel, out_a_sel, out_b_sel,
               save_req, restore_req,
        output out_a, out_b, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/rf_cell.sv
// ============================================================================
// Module      : rf_cell
// Description : One WIDTH-bit register with async active-low reset, FunSel
//               write op under enable, and a priority load port used by the
//               context save/restore engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_cell
    import rf_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             en,
    input  wire logic [2:0]       fun_sel,
    input  wire logic [WIDTH-1:0] din,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    output logic      [WIDTH-1:0] q
);

    // Engine copy beats the FunSel op; otherwise hold unless enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= WIDTH'(rf_next(RF_MAX_W'(q), RF_MAX_W'(din), fun_sel, WIDTH));
        end
    end

endmodule

`default_nettype wire

// File: rtl/param_register_file.sv
// ============================================================================
// Module      : param_register_file
// Description : NUM_GP general + NUM_SCR scratch registers with two
//               combinational read ports and a shadow bank filled/drained by
//               a multi-cycle SAVE/RESTORE engine.
//               Optional macro RF_BYPASS_EN: write-through of I on FunSel=010
//               and shadow forwarding of the register being restored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module param_register_file
    import rf_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NUM_GP  = 4,
    parameter int NUM_SCR = 4
) (
    input wire logic               clk,
    input wire logic               rst_n,
    param_register_file_if.slave   bus
);

    localparam int SEL_W  = $clog2(NUM_GP + NUM_SCR);
    localparam int NUM_RD = NUM_GP + NUM_SCR;
    localparam int IDX_W  = (NUM_GP > 1) ? $clog2(NUM_GP) : 1;

    rf_state_t        state;
    rf_state_t        state_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_next;
    logic             done_q;
    logic             done_next;
    logic             busy;
    logic             last_idx;

    logic [WIDTH-1:0] gp_q  [NUM_GP];
    logic [WIDTH-1:0] scr_q [NUM_SCR];
    logic [WIDTH-1:0] sh_q  [NUM_GP];
    logic [WIDTH-1:0] rd_val[NUM_RD];

    assign busy     = (state != IDLE);
    assign last_idx = (idx == IDX_W'(NUM_GP - 1));

    // Engine state, copy index and the registered Done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_next;
            idx    <= idx_next;
            done_q <= done_next;
        end
    end

    // Next state: SAVE has priority; one register copied per cycle
    always_comb begin
        state_next = state;
        idx_next   = idx;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                idx_next = '0;
                if (bus.save_req) begin
                    state_next = SAVE;
                end else if (bus.restore_req) begin
                    state_next = RESTORE;
                end
            end
            SAVE, RESTORE: begin
                if (last_idx) begin
                    state_next = IDLE;
                    idx_next   = '0;
                    done_next  = 1'b1;
                end else begin
                    idx_next = idx + IDX_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // General registers: writes frozen while the engine runs; restore loads
    generate
        for (genvar g = 0; g < NUM_GP; g++) begin : g_gp
            logic en;
            logic load;
            assign en   = ~bus.reg_sel[NUM_GP-1-g] & ~busy;
            assign load = (state == RESTORE) && (idx == IDX_W'(g));
            rf_cell #(.WIDTH(WIDTH)) u_cell (
                .clk      (clk),
                .rst_n    (rst_n),
                .en       (en),
                .fun_sel  (bus.fun_sel),
                .din      (bus.wdata),
                .load     (load),
                .load_val (sh_q[g]),
                .q        (gp_q[g])
            );
        end
    endgenerate

    // Scratch registers are never touched by the engine
    generate
        for (genvar s = 0; s < NUM_SCR; s++) begin : g_scr
            logic en;
            assign en = ~bus.scr_sel[NUM_SCR-1-s];
            rf_cell #(.WIDTH(WIDTH)) u_cell (
                .clk      (clk),
                .rst_n    (rst_n),
                .en       (en),
                .fun_sel  (bus.fun_sel),
                .din      (bus.wdata),
                .load     (1'b0),
                .load_val ('0),
                .q        (scr_q[s])
            );
        end
    endgenerate

    // Shadow bank: written only through the priority load during SAVE
    generate
        for (genvar g = 0; g < NUM_GP; g++) begin : g_sh
            logic load;
            assign load = (state == SAVE) && (idx == IDX_W'(g));
            rf_cell #(.WIDTH(WIDTH)) u_cell (
                .clk      (clk),
                .rst_n    (rst_n),
                .en       (1'b0),
                .fun_sel  (RF_CLR),
                .din      ('0),
                .load     (load),
                .load_val (gp_q[g]),
                .q        (sh_q[g])
            );
        end
    endgenerate

    // Value each register presents to the read ports
    always_comb begin
        for (int g = 0; g < NUM_GP; g++) begin
            rd_val[g] = gp_q[g];
`ifdef RF_BYPASS_EN
            if (!busy && !bus.reg_sel[NUM_GP-1-g] && bus.fun_sel == RF_LOAD) begin
                rd_val[g] = bus.wdata;
            end else if (state == RESTORE && idx == IDX_W'(g)) begin
                rd_val[g] = sh_q[g];
            end
`endif
        end
        for (int s = 0; s < NUM_SCR; s++) begin
            rd_val[NUM_GP+s] = scr_q[s];
`ifdef RF_BYPASS_EN
            if (!bus.scr_sel[NUM_SCR-1-s] && bus.fun_sel == RF_LOAD) begin
                rd_val[NUM_GP+s] = bus.wdata;
            end
`endif
        end
    end

    // Read port muxes; selects beyond the last scratch register read zero
    always_comb begin
        bus.out_a = '0;
        bus.out_b = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            if (bus.out_a_sel == SEL_W'(r)) bus.out_a = rd_val[r];
            if (bus.out_b_sel == SEL_W'(r)) bus.out_b = rd_val[r];
        end
    end

    assign bus.busy = busy;
    assign bus.done = done_q;

endmodule

`default_nettype wire
